// File: rtl/ir_load_ctrl_pkg.sv
// Shared encodings for the IR load controller: FSM state codes and regfile_ir commands.
package ir_load_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_MEM  = 3'd1;
  localparam logic [2:0] S_WRITE_RF  = 3'd2;
  localparam logic [2:0] S_WORK      = 3'd3;
  localparam logic [2:0] S_FETCH_RD  = 3'd4;
  localparam logic [2:0] S_FETCH_RSP = 3'd5;

  localparam logic [1:0] RF_IDLE  = 2'd0;
  localparam logic [1:0] RF_WRITE = 2'd1;
  localparam logic [1:0] RF_READ  = 2'd2;

endpackage

// File: rtl/ir_load_ctrl.sv
// Loads the IR regfile word-by-word from memory, then serves single-entry fetches from it.
module ir_load_ctrl
  import ir_load_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_base_addr,
  output logic                  o_mem_req,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [1:0]            o_rf_mode,
  output logic [ADDR_W-1:0]     o_rf_address,
  output logic [DATA_WIDTH-1:0] o_rf_data,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic                  i_fetch_req,
  input  logic [ADDR_W-1:0]     i_fetch_addr,
  output logic                  o_fetch_valid,
  output logic [DATA_WIDTH-1:0] o_fetch_data,
  output logic                  o_busy,
  output logic                  o_init_done
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_base;
  logic [ADDR_W-1:0]     r_cnt;
  logic [DATA_WIDTH-1:0] r_word;
  logic [ADDR_W-1:0]     r_fetch_idx;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic                  r_init_done;
  logic                  w_start_acc;
  logic                  w_fetch_acc;
  logic                  w_last;

  assign w_start_acc = i_start && (r_state == S_IDLE || r_state == S_WORK);
  assign w_fetch_acc = (r_state == S_WORK) && i_fetch_req && !i_start;
  assign w_last      = (r_cnt == '1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_state_nxt = S_READ_MEM;
      S_READ_MEM:  if (i_mem_ack) w_state_nxt = S_WRITE_RF;
      S_WRITE_RF:  w_state_nxt = w_last ? S_WORK : S_READ_MEM;
      S_WORK: begin
        if (i_start)          w_state_nxt = S_READ_MEM;
        else if (i_fetch_req) w_state_nxt = S_FETCH_RD;
      end
      S_FETCH_RD:  w_state_nxt = S_FETCH_RSP;
      S_FETCH_RSP: w_state_nxt = S_WORK;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_fetch_idx  <= '0;
      r_fetch_data <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_base      <= i_base_addr;
        r_cnt       <= '0;
        r_init_done <= 1'b0;
      end
      if (r_state == S_READ_MEM && i_mem_ack) r_word <= i_mem_data;
      if (r_state == S_WRITE_RF) begin
        if (w_last) r_init_done <= 1'b1;
        else        r_cnt       <= r_cnt + 1'b1;
      end
      if (w_fetch_acc) r_fetch_idx <= i_fetch_addr;
      if (r_state == S_FETCH_RSP) r_fetch_data <= i_rf_data;
    end
  end

  // Outputs decode from registered state so an async reset forces them all low at once.
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_rf_mode    = RF_IDLE;
    o_rf_address = '0;
    o_rf_data    = '0;
    case (r_state)
      S_READ_MEM: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_base + DATA_WIDTH'(r_cnt);
      end
      S_WRITE_RF: begin
        o_rf_mode    = RF_WRITE;
        o_rf_address = r_cnt;
        o_rf_data    = r_word;
      end
      S_FETCH_RD: begin
        o_rf_mode    = RF_READ;
        o_rf_address = r_fetch_idx;
      end
      default: ;
    endcase
  end

  assign o_fetch_valid = (r_state == S_FETCH_RSP);
  assign o_fetch_data  = o_fetch_valid ? i_rf_data : r_fetch_data;
  assign o_busy        = !(r_state == S_IDLE || r_state == S_WORK);
  assign o_init_done   = r_init_done;

endmodule

// File: tb/tb_ir_load_ctrl.sv
// Scoreboard bench for ir_load_ctrl with behavioural memory and regfile_ir models.
module tb_ir_load_ctrl;
  import ir_load_ctrl_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_base_addr = '0;
  logic          o_mem_req;
  logic [DW-1:0] o_mem_addr;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_data;
  logic [1:0]    o_rf_mode;
  logic [AW-1:0] o_rf_address;
  logic [DW-1:0] o_rf_data;
  logic [DW-1:0] i_rf_data;
  logic          i_fetch_req = 1'b0;
  logic [AW-1:0] i_fetch_addr = '0;
  logic          o_fetch_valid;
  logic [DW-1:0] o_fetch_data;
  logic          o_busy;
  logic          o_init_done;

  ir_load_ctrl #(.DATA_WIDTH(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_data(i_mem_data), .o_rf_mode(o_rf_mode), .o_rf_address(o_rf_address),
    .o_rf_data(o_rf_data), .i_rf_data(i_rf_data), .i_fetch_req(i_fetch_req),
    .i_fetch_addr(i_fetch_addr), .o_fetch_valid(o_fetch_valid),
    .o_fetch_data(o_fetch_data), .o_busy(o_busy), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q_wr[$];
  logic [DW-1:0] q_addr[$];
  logic [DW-1:0] q_fetch[$];
  logic [DW-1:0] exp_rf[16];

  // Memory: ack after ack_delay extra cycles of a held request, data = addr ^ 0xFF.
  int unsigned ack_delay = 0;
  int unsigned wcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wcnt <= 0;
    else if (o_mem_req && !i_mem_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end
  assign i_mem_ack  = o_mem_req && (wcnt >= ack_delay);
  assign i_mem_data = o_mem_addr ^ 8'hFF;

  // regfile_ir: synchronous write, read data one cycle after the read command.
  logic [DW-1:0] rf_mem[16];
  logic [DW-1:0] rf_q = '0;
  always @(posedge clk) begin
    if (o_rf_mode == RF_WRITE) rf_mem[o_rf_address] <= o_rf_data;
    if (o_rf_mode == RF_READ)  rf_q <= rf_mem[o_rf_address];
  end
  assign i_rf_data = rf_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected DUT output expected none at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (o_mem_req) begin
        if (q_addr.size() == 0) unexpected("mem_req");
        else begin
          check("mem_addr", 32'(o_mem_addr), 32'(q_addr[0]));
          if (i_mem_ack) void'(q_addr.pop_front());
        end
      end
      if (o_rf_mode == RF_WRITE) begin
        if (q_wr.size() == 0) unexpected("rf_write");
        else begin
          w = q_wr.pop_front();
          check("rf_wr_addr", 32'(o_rf_address), 32'(w.a));
          check("rf_wr_data", 32'(o_rf_data), 32'(w.d));
          writes_seen++;
        end
      end
      if (o_fetch_valid) begin
        if (q_fetch.size() == 0) unexpected("fetch_valid");
        else check("fetch_data", 32'(o_fetch_data), 32'(q_fetch.pop_front()));
      end
    end
  end

  task automatic start_load(input logic [DW-1:0] base, input bit with_fetch);
    logic [DW-1:0] a;
    for (int i = 0; i < 16; i++) begin
      a = base + DW'(i);
      exp_rf[i] = a ^ 8'hFF;
      q_addr.push_back(a);
      q_wr.push_back({AW'(i), a ^ 8'hFF});
    end
    @(negedge clk);
    i_start = 1'b1;
    i_base_addr = base;
    i_fetch_req = with_fetch;
    i_fetch_addr = 4'd1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_fetch_req = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
    check("init_done_cleared", 32'(o_init_done), 32'd0);
  endtask

  task automatic wait_done(input int exp_cycles, input bit poke);
    int n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (o_init_done || n > exp_cycles + 20) break;
      check("busy_during_load", 32'(o_busy), 32'd1);
      if (poke) begin
        i_fetch_req = n[0];
        i_fetch_addr = 4'd2;
      end
    end
    i_fetch_req = 1'b0;
    check("load_cycles", 32'(n), 32'(exp_cycles));
    check("init_done", 32'(o_init_done), 32'd1);
    check("idle_after_load", 32'(o_busy), 32'd0);
  endtask

  task automatic do_fetch(input int idx);
    q_fetch.push_back(exp_rf[idx]);
    @(negedge clk);
    i_fetch_req = 1'b1;
    i_fetch_addr = AW'(idx);
    @(posedge clk);
    #1;
    i_fetch_req = 1'b0;
    check("fetch_rd_busy", 32'(o_busy), 32'd1);
    @(posedge clk);
    #1;
    check("fetch_latency", 32'(o_fetch_valid), 32'd1);
    @(posedge clk);
    #1;
    check("fetch_pulse_end", 32'(o_fetch_valid), 32'd0);
  endtask

  initial begin
    int guard;
    #1;
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_rf_mode", 32'(o_rf_mode), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_init_done", 32'(o_init_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    ack_delay = 0;
    start_load(8'h20, 1'b0);
    wait_done(32, 1'b0);
    do_fetch(5);
    do_fetch(0);
    do_fetch(15);
    repeat (4) @(posedge clk);
    #1;
    check("fetch_data_hold", 32'(o_fetch_data), 32'h00D0);

    ack_delay = 4;
    start_load(8'h60, 1'b0);
    wait_done(96, 1'b1);
    do_fetch(3);

    ack_delay = 0;
    start_load(8'h20, 1'b0);
    guard = 0;
    begin
      int ws0 = writes_seen;
      while (writes_seen - ws0 < 7 && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
    end
    check("partial_writes_reached", 32'(guard < 100), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(o_mem_req), 32'd0);
    check("midrst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_init_done", 32'(o_init_done), 32'd0);
    check("midrst_fetch_data", 32'(o_fetch_data), 32'd0);
    q_addr.delete();
    q_wr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_load(8'h30, 1'b0);
    wait_done(32, 1'b0);
    do_fetch(6);

    start_load(8'hF8, 1'b0);
    wait_done(32, 1'b0);
    do_fetch(8);
    do_fetch(7);

    start_load(8'h50, 1'b1);
    wait_done(32, 1'b0);
    do_fetch(2);

    repeat (3) @(posedge clk);
    check("q_addr_drained", 32'(q_addr.size()), 32'd0);
    check("q_wr_drained", 32'(q_wr.size()), 32'd0);
    check("q_fetch_drained", 32'(q_fetch.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
